// File: rtl/sap_ctrl_pkg.sv
// Shared constants for the SAP control sequencer: opcodes, one-hot T-states,
// control-word bit positions and the opcode classifier.
package sap_ctrl_pkg;

   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   localparam logic [5:0] T1 = 6'b000001;
   localparam logic [5:0] T2 = 6'b000010;
   localparam logic [5:0] T3 = 6'b000100;
   localparam logic [5:0] T4 = 6'b001000;
   localparam logic [5:0] T5 = 6'b010000;
   localparam logic [5:0] T6 = 6'b100000;

   // Internal control word is active-high; active-low pins are inverted at the port.
   localparam int CW_CP  = 0;
   localparam int CW_EP  = 1;
   localparam int CW_LM  = 2;
   localparam int CW_CE  = 3;
   localparam int CW_LI  = 4;
   localparam int CW_EI  = 5;
   localparam int CW_LA  = 6;
   localparam int CW_EA  = 7;
   localparam int CW_SU  = 8;
   localparam int CW_EU  = 9;
   localparam int CW_LB  = 10;
   localparam int CW_LO  = 11;
   localparam int CW_HLT = 12;
   localparam int CW_W   = 13;

   typedef logic [CW_W-1:0] cword_t;

   typedef enum logic [2:0] {
      OPC_LDA,
      OPC_ADD,
      OPC_SUB,
      OPC_OUT,
      OPC_HLT,
      OPC_NOP
   } op_class_t;

   function automatic op_class_t classify(input logic [3:0] op);
      case (op)
         OP_LDA:  return OPC_LDA;
         OP_ADD:  return OPC_ADD;
         OP_SUB:  return OPC_SUB;
         OP_OUT:  return OPC_OUT;
         OP_HLT:  return OPC_HLT;
         default: return OPC_NOP;
      endcase
   endfunction

endpackage

// File: rtl/sap_control_sequencer_if.sv
// Register control bus between the sequencer (master) and the register slices
// and ALU (slave). Loads and RAM/IR bus enables are active-low.
interface sap_control_sequencer_if #(
   parameter int OPCODE_W = 4
);
   logic                run;
   logic [OPCODE_W-1:0] opcode;
   logic [5:0]          t_state;
   logic                cp;
   logic                ep;
   logic                lm_n;
   logic                ce_n;
   logic                li_n;
   logic                ei_n;
   logic                la_n;
   logic                ea;
   logic                su;
   logic                eu;
   logic                lb_n;
   logic                lo_n;
   logic                hlt;

   modport master (
      input  run, opcode,
      output t_state, cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n, hlt
   );

   modport slave (
      output run, opcode,
      input  t_state, cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n, hlt
   );
endinterface

// File: rtl/sap_ring_counter.sv
// Six-state one-hot ring (T1..T6) with enable and synchronous restart to T1.
module sap_ring_counter
   import sap_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       clr_n,
   input  logic       en,
   input  logic       restart,
   output logic [5:0] ring
);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         ring <= T1;
      end else if (en) begin
         ring <= restart ? T1 : {ring[4:0], ring[5]};
      end
   end

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP control sequencer: T-state ring, arm/halt tracking and micro-op decode
// driving the register control bus.
module sap_control_sequencer
   import sap_ctrl_pkg::*;
#(
   parameter int OPCODE_W  = 4,
   parameter bit EARLY_END = 1'b0
) (
   input  logic                   clk,
   input  logic                   clr_n,
   sap_control_sequencer_if.master bus
);

   logic       armed;
   logic       halted;
   logic [5:0] ring;
   logic [3:0] op4;
   op_class_t  opc;
   logic       active;
   logic       enter_halt;
   logic       last_t;
   logic       restart;
   cword_t     cw;

   assign op4        = 4'(bus.opcode);
   assign opc        = classify(op4);
   assign active     = armed && bus.run && !halted;
   assign enter_halt = active && ring[3] && (opc == OPC_HLT);

   // Last active T-state of each instruction, used only when EARLY_END is set.
   always_comb begin
      last_t = 1'b0;
      case (opc)
         OPC_LDA:          last_t = ring[4];
         OPC_ADD, OPC_SUB: last_t = ring[5];
         OPC_OUT, OPC_NOP: last_t = ring[3];
         default:          last_t = 1'b0;
      endcase
   end

   assign restart = EARLY_END && last_t;

   sap_ring_counter u_ring (
      .clk     (clk),
      .clr_n   (clr_n),
      .en      (active && !enter_halt),
      .restart (restart),
      .ring    (ring)
   );

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         armed  <= 1'b0;
         halted <= 1'b0;
      end else begin
         if (!armed) begin
            armed <= 1'b1;
         end
         if (enter_halt) begin
            halted <= 1'b1;
         end
      end
   end

   always_comb begin
      cw = '0;
      if (halted) begin
         cw[CW_HLT] = 1'b1;
      end else if (armed && bus.run) begin
         case (ring)
            T1: begin
               cw[CW_EP] = 1'b1;
               cw[CW_LM] = 1'b1;
            end
            T2: cw[CW_CP] = 1'b1;
            T3: begin
               cw[CW_CE] = 1'b1;
               cw[CW_LI] = 1'b1;
            end
            T4: begin
               case (opc)
                  OPC_LDA, OPC_ADD, OPC_SUB: begin
                     cw[CW_EI] = 1'b1;
                     cw[CW_LM] = 1'b1;
                  end
                  OPC_OUT: begin
                     cw[CW_EA] = 1'b1;
                     cw[CW_LO] = 1'b1;
                  end
                  OPC_HLT: cw[CW_HLT] = 1'b1;
                  default: cw = '0;
               endcase
            end
            T5: begin
               case (opc)
                  OPC_LDA: begin
                     cw[CW_CE] = 1'b1;
                     cw[CW_LA] = 1'b1;
                  end
                  OPC_ADD, OPC_SUB: begin
                     cw[CW_CE] = 1'b1;
                     cw[CW_LB] = 1'b1;
                  end
                  default: cw = '0;
               endcase
            end
            T6: begin
               if (opc == OPC_ADD || opc == OPC_SUB) begin
                  cw[CW_EU] = 1'b1;
                  cw[CW_LA] = 1'b1;
                  cw[CW_SU] = (opc == OPC_SUB);
               end
            end
            default: cw = '0;
         endcase
      end
   end

   assign bus.t_state = halted ? 6'b000000 : ring;
   assign bus.cp      =  cw[CW_CP];
   assign bus.ep      =  cw[CW_EP];
   assign bus.lm_n    = ~cw[CW_LM];
   assign bus.ce_n    = ~cw[CW_CE];
   assign bus.li_n    = ~cw[CW_LI];
   assign bus.ei_n    = ~cw[CW_EI];
   assign bus.la_n    = ~cw[CW_LA];
   assign bus.ea      =  cw[CW_EA];
   assign bus.su      =  cw[CW_SU];
   assign bus.eu      =  cw[CW_EU];
   assign bus.lb_n    = ~cw[CW_LB];
   assign bus.lo_n    = ~cw[CW_LO];
   assign bus.hlt     =  cw[CW_HLT];

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Bench for sap_control_sequencer: one instance with full T1..T6 runs and one
// with early end, each checked every cycle against a behavioural model.
module tb_sap_control_sequencer;
   import sap_ctrl_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic clr_n0, clr_n1;

   sap_control_sequencer_if #(.OPCODE_W(4)) if0 ();
   sap_control_sequencer_if #(.OPCODE_W(4)) if1 ();

   sap_control_sequencer #(.OPCODE_W(4), .EARLY_END(1'b0)) dut0 (
      .clk(clk), .clr_n(clr_n0), .bus(if0.master));
   sap_control_sequencer #(.OPCODE_W(4), .EARLY_END(1'b1)) dut1 (
      .clk(clk), .clr_n(clr_n1), .bus(if1.master));

   int n_checks = 0;
   int n_fail   = 0;

   int   m_t[2];
   bit   m_armed[2];
   bit   m_halted[2];
   logic [18:0] sb_q[$];
   logic [18:0] lst[2];

   // Observation vector: {t_state, cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n, hlt}
   localparam logic [12:0] IDLE_WORD = 13'b0011111000110;

   function automatic logic get_run(int d);
      return (d == 0) ? if0.run : if1.run;
   endfunction

   function automatic logic [3:0] get_op(int d);
      return (d == 0) ? if0.opcode : if1.opcode;
   endfunction

   function automatic logic get_clr(int d);
      return (d == 0) ? clr_n0 : clr_n1;
   endfunction

   function automatic logic [18:0] obs(int d);
      if (d == 0)
         return {if0.t_state, if0.cp, if0.ep, if0.lm_n, if0.ce_n, if0.li_n, if0.ei_n,
                 if0.la_n, if0.ea, if0.su, if0.eu, if0.lb_n, if0.lo_n, if0.hlt};
      return {if1.t_state, if1.cp, if1.ep, if1.lm_n, if1.ce_n, if1.li_n, if1.ei_n,
              if1.la_n, if1.ea, if1.su, if1.eu, if1.lb_n, if1.lo_n, if1.hlt};
   endfunction

   function automatic logic [18:0] model_out(int d, logic run, logic [3:0] op);
      logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, h;
      logic [5:0] ts;
      {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, h} = '0;
      ts = m_halted[d] ? 6'b0 : (6'b1 << (m_t[d] - 1));
      if (m_halted[d]) h = 1'b1;
      else if (m_armed[d] && run) begin
         case (m_t[d])
            1: begin ep = 1; lm = 1; end
            2: cp = 1;
            3: begin ce = 1; li = 1; end
            4: begin
               if (op == 4'b0000 || op == 4'b0001 || op == 4'b0010) begin ei = 1; lm = 1; end
               else if (op == 4'b1110) begin ea = 1; lo = 1; end
               else if (op == 4'b1111) h = 1;
            end
            5: begin
               if (op == 4'b0000) begin ce = 1; la = 1; end
               else if (op == 4'b0001 || op == 4'b0010) begin ce = 1; lb = 1; end
            end
            6: if (op == 4'b0001 || op == 4'b0010) begin eu = 1; la = 1; su = (op == 4'b0010); end
            default: ;
         endcase
      end
      return {ts, cp, ep, ~lm, ~ce, ~li, ~ei, ~la, ea, su, eu, ~lb, ~lo, h};
   endfunction

   task automatic model_reset(int d);
      m_t[d] = 1; m_armed[d] = 0; m_halted[d] = 0;
   endtask

   task automatic step_model(int d);
      logic run;
      logic [3:0] op;
      bit fin;
      run = get_run(d);
      op  = get_op(d);
      if (!get_clr(d)) model_reset(d);
      else if (m_halted[d]) ;
      else if (!m_armed[d]) m_armed[d] = 1;
      else if (run) begin
         if (m_t[d] == 4 && op == 4'b1111) m_halted[d] = 1;
         else begin
            fin = (op == 4'b0000 && m_t[d] == 5) ||
                  ((op == 4'b0001 || op == 4'b0010) && m_t[d] == 6) ||
                  (op == 4'b1110 && m_t[d] == 4) ||
                  (!(op inside {4'b0000, 4'b0001, 4'b0010, 4'b1110, 4'b1111}) && m_t[d] == 4);
            if (d == 1 && fin) m_t[d] = 1;
            else m_t[d] = (m_t[d] == 6) ? 1 : m_t[d] + 1;
         end
      end
   endtask

   // One clock: sample both DUTs mid-low-phase, then advance the models on the edge.
   task automatic cycle();
      logic [18:0] e, o;
      logic [4:0] drv;
      @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) sb_q.push_back(model_out(d, get_run(d), get_op(d)));
      for (int d = 0; d < 2; d++) begin
         e = sb_q.pop_front();
         o = obs(d);
         lst[d] = o;
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL cycle_word dut%0d t=%0t: got %b expected %b", d, $time, o, e);
         end
         drv = {o[11], ~o[9], ~o[7], o[5], o[3]};
         n_checks++;
         if ($countones(drv) > 1) begin
            n_fail++;
            $display("FAIL bus_drivers dut%0d t=%0t: got %b expected at most one set", d, $time, drv);
         end
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) step_model(d);
   endtask

   task automatic reset_dut(int d);
      if (d == 0) begin clr_n0 = 0; if0.run = 0; end
      else begin clr_n1 = 0; if1.run = 0; end
      model_reset(d);
      cycle();
      if (d == 0) clr_n0 = 1; else clr_n1 = 1;
   endtask

   task automatic test_reset();
      clr_n0 = 0; clr_n1 = 0;
      if0.run = 1; if1.run = 1;
      if0.opcode = 4'b0001; if1.opcode = 4'b1110;
      model_reset(0); model_reset(1);
      #2;
      for (int k = 0; k < 3; k++) begin
         cycle();
         n_checks++;
         if (lst[0] !== {6'b000001, IDLE_WORD}) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected %b", lst[0], {6'b000001, IDLE_WORD});
         end
      end
      clr_n0 = 1; clr_n1 = 1;
      if0.run = 0; if1.run = 0;
   endtask

   task automatic test_lda_walk();
      int exp_ts[9] = '{1, 1, 2, 4, 8, 16, 32, 1, 2};
      reset_dut(0);
      if0.run = 1; if0.opcode = OP_LDA;
      for (int i = 0; i < 9; i++) begin
         cycle();
         n_checks++;
         if (lst[0][18:13] !== 6'(exp_ts[i])) begin
            n_fail++;
            $display("FAIL lda_tstate step%0d: got %b expected %b", i, lst[0][18:13], 6'(exp_ts[i]));
         end
         if (i == 0 || i == 1 || i == 3 || i == 5) begin
            n_checks++;
            if ((i == 0 && lst[0][12:0] !== IDLE_WORD) ||
                (i == 1 && {lst[0][11], lst[0][10]} !== 2'b10) ||
                (i == 3 && {lst[0][9], lst[0][8]} !== 2'b00) ||
                (i == 5 && lst[0][6] !== 1'b0)) begin
               n_fail++;
               $display("FAIL lda_ctrl step%0d: got %b", i, lst[0][12:0]);
            end
         end
      end
   endtask

   task automatic test_add_sub();
      logic [3:0] ops[2] = '{4'b0010, 4'b0001};
      for (int j = 0; j < 2; j++) begin
         reset_dut(0);
         if0.run = 1; if0.opcode = ops[j];
         for (int i = 0; i < 8; i++) begin
            cycle();
            if (i == 5) begin
               n_checks++;
               if (lst[0][2] !== 1'b0) begin
                  n_fail++;
                  $display("FAIL alu_t5_lb op%b: got lb_n=%b expected 0", ops[j], lst[0][2]);
               end
            end
            if (i == 6) begin
               n_checks++;
               if ({lst[0][3], lst[0][6], lst[0][4]} !== {2'b10, (j == 0)}) begin
                  n_fail++;
                  $display("FAIL alu_t6 op%b: got eu,la_n,su=%b expected %b", ops[j],
                           {lst[0][3], lst[0][6], lst[0][4]}, {2'b10, (j == 0)});
               end
            end
         end
      end
   endtask

   task automatic test_halt();
      int n;
      reset_dut(0);
      if0.run = 1; if0.opcode = OP_HLT;
      n = 0;
      while (!m_halted[0] && n < 20) begin cycle(); n++; end
      n_checks++;
      if (!m_halted[0] || lst[0][0] !== 1'b1 || lst[0][18:13] !== 6'b001000) begin
         n_fail++;
         $display("FAIL halt_t4: got %b expected t_state 001000 with hlt=1", lst[0]);
      end
      for (int k = 0; k < 20; k++) begin
         if0.run = 1'($urandom_range(0, 1));
         if0.opcode = 4'($urandom_range(0, 15));
         cycle();
         n_checks++;
         if (lst[0] !== {6'b000000, 13'b0011111000111}) begin
            n_fail++;
            $display("FAIL halted_hold k%0d: got %b expected %b", k, lst[0], {6'b000000, 13'b0011111000111});
         end
      end
      clr_n0 = 0;
      #1;
      n_checks++;
      if (if0.t_state !== 6'b000001 || if0.hlt !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_clear: got t_state=%b hlt=%b expected 000001 0", if0.t_state, if0.hlt);
      end
      model_reset(0);
      cycle();
      clr_n0 = 1;
      if0.run = 0;
   endtask

   task automatic test_early_end();
      int exp_out[7] = '{1, 1, 2, 4, 8, 1, 2};
      int exp_lda[8] = '{1, 1, 2, 4, 8, 16, 1, 2};
      reset_dut(1);
      if1.run = 1; if1.opcode = OP_OUT;
      for (int i = 0; i < 7; i++) begin
         cycle();
         n_checks++;
         if (lst[1][18:13] !== 6'(exp_out[i])) begin
            n_fail++;
            $display("FAIL early_out step%0d: got %b expected %b", i, lst[1][18:13], 6'(exp_out[i]));
         end
         if (i == 4) begin
            n_checks++;
            if ({lst[1][5], lst[1][1]} !== 2'b10) begin
               n_fail++;
               $display("FAIL early_out_t4: got ea,lo_n=%b expected 10", {lst[1][5], lst[1][1]});
            end
         end
      end
      reset_dut(1);
      if1.run = 1; if1.opcode = OP_LDA;
      for (int i = 0; i < 8; i++) begin
         cycle();
         n_checks++;
         if (lst[1][18:13] !== 6'(exp_lda[i])) begin
            n_fail++;
            $display("FAIL early_lda step%0d: got %b expected %b", i, lst[1][18:13], 6'(exp_lda[i]));
         end
      end
      reset_dut(1);
      if1.run = 1; if1.opcode = 4'b0001;
      for (int i = 0; i < 9; i++) cycle();
      if1.opcode = 4'b0101;
      for (int i = 0; i < 8; i++) cycle();
      if1.run = 0;
   endtask

   task automatic test_run_hold();
      int n;
      reset_dut(0);
      if0.run = 1; if0.opcode = OP_ADD;
      n = 0;
      while (m_t[0] != 4 && n < 20) begin cycle(); n++; end
      if0.run = 0;
      for (int k = 0; k < 3; k++) begin
         cycle();
         n_checks++;
         if (lst[0] !== {6'b001000, IDLE_WORD}) begin
            n_fail++;
            $display("FAIL run_hold k%0d: got %b expected %b", k, lst[0], {6'b001000, IDLE_WORD});
         end
      end
      if0.run = 1;
      cycle();
      n_checks++;
      if ({lst[0][18:13], lst[0][7], lst[0][10]} !== {6'b001000, 2'b00}) begin
         n_fail++;
         $display("FAIL run_resume: got t_state=%b ei_n=%b lm_n=%b expected 001000 0 0",
                  lst[0][18:13], lst[0][7], lst[0][10]);
      end
      for (int k = 0; k < 4; k++) cycle();
   endtask

   task automatic test_async_reset();
      int n;
      reset_dut(0);
      if0.run = 1; if0.opcode = OP_LDA;
      n = 0;
      while (m_t[0] != 5 && n < 20) begin cycle(); n++; end
      #1;
      n_checks++;
      if (if0.la_n !== 1'b0 || if0.ce_n !== 1'b0) begin
         n_fail++;
         $display("FAIL async_pre_t5: got la_n=%b ce_n=%b expected 0 0", if0.la_n, if0.ce_n);
      end
      clr_n0 = 0;
      #1;
      n_checks++;
      if (obs(0) !== {6'b000001, IDLE_WORD}) begin
         n_fail++;
         $display("FAIL async_reset: got %b expected %b", obs(0), {6'b000001, IDLE_WORD});
      end
      model_reset(0);
      cycle();
      clr_n0 = 1;
      for (int k = 0; k < 4; k++) cycle();
   endtask

   initial begin
      if0.run = 0; if0.opcode = 4'b0000;
      if1.run = 0; if1.opcode = 4'b0000;
      test_reset();
      test_lda_walk();
      test_add_sub();
      test_halt();
      test_early_end();
      test_run_hold();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sap_control_sequencer.md
Name: sap_control_sequencer

Overview:
- Control sequencer for the SAP-style 8-bit datapath. It generates the load-enable and output-enable lines that the quad-register slices (A, B, IR, MAR, OUT) consume.
- It is the driving end of the register control interface. Loads and register output enables are active-low, matching the register G and M/N inputs.
- A ring counter steps T1..T6 through fetch and execute. The opcode nibble from the instruction register selects the execute micro-ops; a halted state freezes the machine.

Parameters:
- OPCODE_W, 4, width of opcode input.
- EARLY_END, 0, 1 = return to T1 right after the last active T-state of an instruction; 0 = always run the full T1..T6.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- clr_n  in  1  asynchronous active-low reset.
- run  in  1  1 = sequencer advances; 0 = hold state, control word forced inactive.
- opcode  in  OPCODE_W  IR upper nibble; valid from T4 onward.
- t_state  out  6  one-hot current T-state (bit0 = T1); 0 while halted.
- cp  out  1  PC increment (active-high).
- ep  out  1  PC drive bus (active-high).
- lm_n  out  1  MAR load (active-low).
- ce_n  out  1  RAM drive bus (active-low).
- li_n  out  1  IR load (active-low).
- ei_n  out  1  IR operand drive bus (active-low).
- la_n  out  1  A load (active-low).
- ea  out  1  A drive bus (active-high).
- su  out  1  ALU subtract select.
- eu  out  1  ALU drive bus (active-high).
- lb_n  out  1  B load (active-low).
- lo_n  out  1  OUT register load (active-low).
- hlt  out  1  halted indicator.

Behaviour:
- States: one-hot ring T1..T6, plus HALTED. An armed flag is reset to 0 and set on the first rising edge after clr_n deasserts. The ring stays in T1 on that edge.
- Reset (clr_n=0, async):
  - ring = T1, armed = 0.
  - All outputs inactive: cp=ep=ea=eu=su=hlt=0, every *_n = 1, t_state = 6'b000001.
- Control word is a combinational decode of state and opcode. It is forced inactive when armed=0 or run=0.
- Ring advances T(k) -> T(k+1) on each edge with run=1 and armed=1. T6 -> T1 wraps.
- run=0 holds state. Deasserting run mid-instruction resumes at the same T-state.
- Fetch, all opcodes:
  - T1: ep, lm_n=0.
  - T2: cp.
  - T3: ce_n=0, li_n=0.
- Execute, opcode sampled per cycle:
  - LDA 0000: T4 ei_n=0, lm_n=0; T5 ce_n=0, la_n=0; T6 none.
  - ADD 0001: T4 ei_n=0, lm_n=0; T5 ce_n=0, lb_n=0; T6 eu, la_n=0, su=0.
  - SUB 0010: as ADD, but su=1 in T6.
  - OUT 1110: T4 ea, lo_n=0; T5/T6 none.
  - HLT 1111: T4 hlt=1. Next edge enters HALTED.
  - Any other opcode: NOP, T4..T6 inactive.
- HALTED:
  - hlt=1, all other controls inactive, t_state=0.
  - Ignores run and opcode. Exited only by clr_n.
- EARLY_END=1: the ring returns to T1 instead of advancing after:
  - LDA T5;
  - ADD/SUB T6;
  - OUT T4;
  - undefined opcode T3+1 (i.e. at T4).
- Invariant: at most one bus driver (ep, ~ce_n, ~ei_n, ea, eu) is active in any cycle.
- Reset mid-instruction: immediately returns to T1 with outputs inactive. This applies from HALTED as well.

Decomposition:
- Package sap_ctrl_pkg holds:
  - opcode constants (OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT);
  - one-hot T-state constants;
  - control-word bit index constants.
- Sub-module sap_ring_counter: 6-bit one-hot ring with async active-low reset, enable, and synchronous restart input. The top level holds armed/HALTED and the micro-op decode.

Test Plan:
- Reset then run=1, opcode=0000, EARLY_END=0 -> the first edge only arms. Then t_state walks 000001..100000 and wraps. T1 ep=1, lm_n=0; T3 ce_n=0, li_n=0; T5 la_n=0.
- opcode=0010 -> T5 lb_n=0; T6 eu=1, la_n=0, su=1. opcode=0001 gives the same with su=0.
- opcode=1111 -> hlt=1 at T4, then HALTED: t_state=0 with all controls inactive for 20 cycles regardless of run. Pulsing clr_n low returns t_state=000001, hlt=0.
- EARLY_END=1, opcode=1110 -> after T4 (ea=1, lo_n=0) the next t_state is 000001. LDA returns to T1 after T5.
- run dropped at T4 for 3 cycles -> t_state stays 001000, control word inactive. On resume, the T4 word appears and the sequence continues.
- clr_n asserted asynchronously mid-T5 -> outputs go inactive without waiting for a clock edge, and t_state=000001. Every cycle is checked for at most one bus driver active.
